// File: rtl/store_monitor_pkg.sv
// Shared types and constants for the store monitor: FSM state encoding
// and fail-code values reported on fail_code.
package store_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ADDR    = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;
    localparam logic [1:0] FC_DATA    = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Clear dominates; otherwise count up while enabled until full scale.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/store_monitor.sv
// Watches CPU data-memory stores and decides whether a test program
// passed (correct data stored to PASS_ADDR) or failed (store to an
// unexpected address, wrong pass data, or optional watchdog expiry).
// Optional watchdog: define STORE_MONITOR_TIMEOUT_EN to compile it in.
module store_monitor
    import store_monitor_pkg::*;
#(
    parameter logic [31:0] PASS_ADDR      = 32'd84,
    parameter logic [31:0] PASS_DATA      = 32'd7,
    parameter logic [31:0] ALLOW_ADDR     = 32'd80,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [15:0] store_count,
    output logic [31:0] bad_addr,
    output logic [31:0] bad_data
);

    state_t state_reg;
    logic   in_run;
    logic   store_in_run;
    logic   hit_pass_addr;
    logic   hit_allow_addr;
    logic   wd_expire;

    assign in_run         = (state_reg == ST_RUN);
    assign store_in_run   = in_run && memwrite;
    assign hit_pass_addr  = (dataadr == PASS_ADDR);
    assign hit_allow_addr = (dataadr == ALLOW_ADDR);

    // Every store seen in RUN counts, including the one that ends the run.
    sat_counter #(.WIDTH(16)) u_store_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (store_in_run),
        .count (store_count)
    );

`ifdef STORE_MONITOR_TIMEOUT_EN
    logic [31:0] wd_count;

    // Watchdog counts cycles spent in RUN since the last reset.
    sat_counter #(.WIDTH(32)) u_watchdog (
        .clk   (clk),
        .clr   (rst),
        .en    (in_run),
        .count (wd_count)
    );

    // Expires on the TIMEOUT_CYCLES-th cycle in RUN (count still one short).
    assign wd_expire = ({1'b0, wd_count} + 33'd1) >= {1'b0, TIMEOUT_CYCLES};
`else
    // No watchdog in this build; the parameter only keeps the interface uniform.
    assign wd_expire = 1'b0 & (TIMEOUT_CYCLES == 32'd0);
`endif

    // Run/pass/fail FSM with registered verdict and failure capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_RUN;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= FC_NONE;
            bad_addr  <= '0;
            bad_data  <= '0;
        end else if (in_run) begin
            if (memwrite && hit_pass_addr) begin
                // Pass address checked first so it wins if it equals ALLOW_ADDR.
                done <= 1'b1;
                if (writedata == PASS_DATA) begin
                    state_reg <= ST_PASS;
                    pass      <= 1'b1;
                end else begin
                    state_reg <= ST_FAIL;
                    fail_code <= FC_DATA;
                    bad_addr  <= dataadr;
                    bad_data  <= writedata;
                end
            end else if (memwrite && !hit_allow_addr) begin
                state_reg <= ST_FAIL;
                done      <= 1'b1;
                fail_code <= FC_ADDR;
                bad_addr  <= dataadr;
                bad_data  <= writedata;
            end else if (wd_expire) begin
                // Only reached when no terminal store occurred this cycle.
                state_reg <= ST_FAIL;
                done      <= 1'b1;
                fail_code <= FC_TIMEOUT;
            end
        end
    end

endmodule
